cflog_write_arbiter: RTL
========================

# cflog_write_arbiter

Shares the single CFLog memory write port between the hardware log monitor (non-stallable writes) and the SpecCFA sub-path engine (valid/ready writes that rewrite log slots with speculated block IDs). Monitor writes have priority and pass through a 2-entry FIFO. A bounded-wait counter guarantees SpecCFA progress. A flush sequencer drains pending writes before the log is handed to attestation.

## Interface
- `LOG_SIZE`, 16'h0100: CFLog size in bytes; overwritten by parent.
- `SPEC_MAX_WAIT`, 4: cycles a pending SpecCFA request may lose arbitration before it is forced through.
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `mon_wr_en`  in  1  monitor write strobe; cannot be stalled.
- `mon_addr`  in  16  monitor CFLog byte address.
- `mon_data`  in  16  monitor log word.
- `spec_valid`  in  1  SpecCFA write request.
- `spec_addr`  in  16  SpecCFA CFLog byte address.
- `spec_data`  in  16  SpecCFA log word (block ID).
- `spec_ready`  out  1  combinational grant; a transfer occurs when `spec_valid && spec_ready`.
- `flush_req`  in  1  single-cycle pulse requesting a drain before attestation.
- `flush_done`  out  1  single-cycle pulse; all writes accepted before it are committed.
- `mem_wr_en`  out  1  registered memory write enable.
- `mem_addr`  out  16  registered memory address.
- `mem_data`  out  16  registered memory data.
- `busy`  out  1  registered; high when the FIFO is non-empty or the FSM is not in ARB.
- `overflow_err`  out  1  sticky bounds error; see Configuration.

## Operation
- FSM states:
  - ARB (reset state).
  - DRAIN: entered from ARB on `flush_req`.
  - DONE: entered from DRAIN when the FIFO count is 0 and no `mon_wr_en` is present. Lasts one cycle with `flush_done`=1, then returns to ARB.
  - `flush_req` outside ARB is ignored.
- Monitor candidate is the FIFO head if the FIFO is non-empty, otherwise `mon_addr`/`mon_data` when `mon_wr_en`=1.
- Arbitration, evaluated in ARB only:
  - Spec wins when `spec_valid` and there is no monitor candidate.
  - Spec also wins when `spec_valid`, `wait_cnt` >= `SPEC_MAX_WAIT`, and the FIFO count is less than 2.
  - Otherwise the monitor wins.
- `spec_ready` is 1 only when spec wins. It is 0 in DRAIN, in DONE, and while reset is asserted.
- In DRAIN, the monitor always wins.
- FIFO update rules:
  - Monitor wins, FIFO empty: `mon_wr_en` bypasses the FIFO; no push.
  - Monitor wins, FIFO non-empty: pop the head; push `mon_wr_en` if present.
  - Spec wins: push `mon_wr_en` if present; no pop.
- FIFO full while spec has priority: the monitor wins. The FIFO therefore never overflows and a monitor write is never dropped.
- `wait_cnt` is 3 bits wide:
  - Increments, saturating at 7, when `spec_valid` is high and spec does not win.
  - Clears to 0 on a spec grant or when `spec_valid` is 0.
- Every winner is registered into `mem_*` with `mem_wr_en`=1. In cycles with no winner, `mem_wr_en` is 0 and `mem_addr`/`mem_data` hold their last values.
- Ordering:
  - Monitor writes commit in issue order.
  - A spec write never commits ahead of a monitor write that was issued in an earlier cycle to the same address. The FIFO count must be 0 for a same-address spec grant; otherwise spec waits.

## Timing
- Reset (asynchronous, while `reset`=0):
  - `mem_wr_en`, `mem_addr`, `mem_data`, `flush_done`, `busy`, `overflow_err` are all 0.
  - FIFO is empty, `wait_cnt` is 0, FSM is in ARB.
- Reset asserted mid-operation discards FIFO contents and any pending flush.
- Latency, monitor bypass: `mon_wr_en` at edge N gives `mem_wr_en` after edge N+1.
- Latency, spec: handshake at edge N gives `mem_wr_en` after edge N+1.
- Worst-case spec wait with the FIFO not full is `SPEC_MAX_WAIT`+1 cycles.
- `flush_done` asserts no earlier than 2 cycles after `flush_req`, and only after the last FIFO entry's `mem_wr_en` cycle.

## Configuration
- `CFLOG_WR_BOUNDS_EN` defined:
  - Any winning write with `addr` >= `LOG_SIZE`-1 is suppressed (`mem_wr_en` stays 0).
  - The write is still consumed: the FIFO is popped and the spec handshake completes.
  - `overflow_err` is set in the same registered cycle and stays set until reset or DONE.
- `CFLOG_WR_BOUNDS_EN` undefined: `overflow_err` is tied to 0 and all writes pass through unchecked.

## Structure
- Package `cflog_arb_pkg` contains:
  - the FSM state enum (ARB, DRAIN, DONE);
  - `MON_FIFO_DEPTH`=2;
  - the 16-bit address and data width constants;
  - the default `LOG_SIZE`.
- Sub-module `cflog_mon_fifo` is a 2-entry FIFO with push, pop, head, count, and asynchronous active-low clear. Arbitration and the FSM stay in the top module.

## Test plan
- Bypass: `mon_wr_en`=1 for one cycle, addr 16'h0004, data 16'hE0A2 -> next cycle `mem_wr_en`=1 with addr 16'h0004, data 16'hE0A2; `busy` stays 0.
- Starvation: `spec_valid` held, addr 16'h0010; monitor writes every other cycle -> `spec_ready`=1 by cycle 5; the monitor write in the grant cycle commits the following cycle.
- FIFO full: spec forced twice while the monitor writes 16'h0020 and 16'h0022 -> count=2, `spec_ready`=0 until count<2; monitor commits are in order.
- Flush: 2 entries queued, then `flush_req` -> `spec_ready`=0, two `mem_wr_en` cycles, then `flush_done` for exactly 1 cycle, then back to ARB.
- Reset mid-drain: assert `reset`=0 during DRAIN -> all outputs 0 immediately; after release, FIFO is empty and there is no `flush_done`.
- `CFLOG_WR_BOUNDS_EN`, `LOG_SIZE`=16'h0100: monitor write to 16'h00FF -> `mem_wr_en`=0 and `overflow_err`=1; a later write to 16'h00FE commits.

Source files
------------

// File: rtl/cflog_arb_pkg.sv
// Shared types and constants for the CFLog write arbiter and its monitor FIFO.
package cflog_arb_pkg;

    localparam int ADDR_W         = 16;
    localparam int DATA_W         = 16;
    localparam int WAIT_W         = 3;
    localparam int MON_FIFO_DEPTH = 2;
    localparam int FIFO_PTR_W     = $clog2(MON_FIFO_DEPTH);
    localparam int FIFO_CNT_W     = $clog2(MON_FIFO_DEPTH + 1);

    localparam logic [ADDR_W-1:0] LOG_SIZE_DEFAULT = 16'h0100;

    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_t;

endpackage

// File: rtl/cflog_mon_fifo.sv
// Small FIFO holding monitor writes that lost arbitration; also reports whether
// any queued entry targets a given address so a spec write cannot overtake it.
module cflog_mon_fifo
    import cflog_arb_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [ADDR_W-1:0]     push_addr,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    input  logic [ADDR_W-1:0]     match_addr,
    output logic [ADDR_W-1:0]     head_addr,
    output logic [DATA_W-1:0]     head_data,
    output logic [FIFO_CNT_W-1:0] count,
    output logic                  match_hit
);

    logic [FIFO_PTR_W-1:0]                        wr_ptr_reg;
    logic [FIFO_PTR_W-1:0]                        rd_ptr_reg;
    logic [FIFO_CNT_W-1:0]                        count_reg;
    logic [MON_FIFO_DEPTH-1:0][ADDR_W-1:0]        addr_vec;
    logic [MON_FIFO_DEPTH-1:0][DATA_W-1:0]        data_vec;
    logic [MON_FIFO_DEPTH-1:0]                    hit_vec;

    genvar gi;
    generate
        for (gi = 0; gi < MON_FIFO_DEPTH; gi++) begin : g_entry
            logic [ADDR_W-1:0]     addr_reg;
            logic [DATA_W-1:0]     data_reg;
            logic [FIFO_PTR_W-1:0] offset;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    addr_reg <= '0;
                    data_reg <= '0;
                end else if (push && (wr_ptr_reg == FIFO_PTR_W'(gi))) begin
                    addr_reg <= push_addr;
                    data_reg <= push_data;
                end
            end

            // Entry is live when its distance from the read pointer is below the count.
            assign offset      = FIFO_PTR_W'(gi) - rd_ptr_reg;
            assign addr_vec[gi] = addr_reg;
            assign data_vec[gi] = data_reg;
            assign hit_vec[gi]  = (FIFO_CNT_W'(offset) < count_reg) && (addr_reg == match_addr);
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + FIFO_PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + FIFO_PTR_W'(1);
            end
            if (push && !pop) begin
                count_reg <= count_reg + FIFO_CNT_W'(1);
            end else if (pop && !push) begin
                count_reg <= count_reg - FIFO_CNT_W'(1);
            end
        end
    end

    assign head_addr = addr_vec[rd_ptr_reg];
    assign head_data = data_vec[rd_ptr_reg];
    assign count     = count_reg;
    assign match_hit = |hit_vec;

endmodule

// File: rtl/cflog_write_arbiter.sv
// Arbitrates the CFLog write port between the monitor and SpecCFA, with a
// flush sequencer. Optional bounds checking is enabled by CFLOG_WR_BOUNDS_EN.
module cflog_write_arbiter
    import cflog_arb_pkg::*;
#(
    parameter logic [ADDR_W-1:0] LOG_SIZE      = LOG_SIZE_DEFAULT,
    parameter int                SPEC_MAX_WAIT = 4
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              mon_wr_en,
    input  logic [ADDR_W-1:0] mon_addr,
    input  logic [DATA_W-1:0] mon_data,
    input  logic              spec_valid,
    input  logic [ADDR_W-1:0] spec_addr,
    input  logic [DATA_W-1:0] spec_data,
    output logic              spec_ready,
    input  logic              flush_req,
    output logic              flush_done,
    output logic              mem_wr_en,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic              busy,
    output logic              overflow_err
);

`ifdef CFLOG_WR_BOUNDS_EN
    localparam bit BOUNDS_EN = 1'b1;
`else
    localparam bit BOUNDS_EN = 1'b0;
`endif

    localparam logic [WAIT_W-1:0] MAX_WAIT =
        (SPEC_MAX_WAIT > 7) ? 3'd7 : WAIT_W'(SPEC_MAX_WAIT);

    arb_state_t              state_reg, state_next;
    logic [WAIT_W-1:0]       wait_cnt_reg, wait_cnt_next;
    logic                    mem_wr_en_reg;
    logic [ADDR_W-1:0]       mem_addr_reg;
    logic [DATA_W-1:0]       mem_data_reg;
    logic                    busy_reg;
    logic                    flush_done_reg;
    logic                    overflow_reg;

    logic [ADDR_W-1:0]       head_addr;
    logic [DATA_W-1:0]       head_data;
    logic [FIFO_CNT_W-1:0]   fifo_count, fifo_count_next;
    logic                    fifo_hazard;

    logic                    fifo_empty, mon_cand, spec_win, mon_win, win_valid;
    logic                    fifo_push, fifo_pop, bounds_hit;
    logic [ADDR_W-1:0]       win_addr;
    logic [DATA_W-1:0]       win_data;

    cflog_mon_fifo u_mon_fifo (
        .clk        (clk),
        .reset      (reset),
        .push       (fifo_push),
        .push_addr  (mon_addr),
        .push_data  (mon_data),
        .pop        (fifo_pop),
        .match_addr (spec_addr),
        .head_addr  (head_addr),
        .head_data  (head_data),
        .count      (fifo_count),
        .match_hit  (fifo_hazard)
    );

    always_comb begin
        fifo_empty = (fifo_count == '0);
        mon_cand   = !fifo_empty || mon_wr_en;
        // A forced spec grant needs FIFO room and no queued write to the same slot.
        spec_win   = reset && (state_reg == ST_ARB) && spec_valid &&
                     (!mon_cand ||
                      ((wait_cnt_reg >= MAX_WAIT) &&
                       (fifo_count < FIFO_CNT_W'(MON_FIFO_DEPTH)) && !fifo_hazard));
        mon_win    = reset && mon_cand && !spec_win;
        win_valid  = spec_win || mon_win;
        fifo_push  = mon_wr_en && (spec_win || !fifo_empty);
        fifo_pop   = mon_win && !fifo_empty;

        win_addr = mon_addr;
        win_data = mon_data;
        if (spec_win) begin
            win_addr = spec_addr;
            win_data = spec_data;
        end else if (!fifo_empty) begin
            win_addr = head_addr;
            win_data = head_data;
        end
        bounds_hit = BOUNDS_EN && win_valid && (win_addr >= (LOG_SIZE - 16'd1));

        fifo_count_next = fifo_count;
        if (fifo_push && !fifo_pop) begin
            fifo_count_next = fifo_count + FIFO_CNT_W'(1);
        end else if (fifo_pop && !fifo_push) begin
            fifo_count_next = fifo_count - FIFO_CNT_W'(1);
        end

        wait_cnt_next = wait_cnt_reg;
        if (!spec_valid || spec_win) begin
            wait_cnt_next = '0;
        end else if (wait_cnt_reg != '1) begin
            wait_cnt_next = wait_cnt_reg + WAIT_W'(1);
        end

        state_next = state_reg;
        case (state_reg)
            ST_ARB:   if (flush_req) state_next = ST_DRAIN;
            ST_DRAIN: if (fifo_empty && !mon_wr_en) state_next = ST_DONE;
            ST_DONE:  state_next = ST_ARB;
            default:  state_next = ST_ARB;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= ST_ARB;
            wait_cnt_reg   <= '0;
            mem_wr_en_reg  <= 1'b0;
            mem_addr_reg   <= '0;
            mem_data_reg   <= '0;
            busy_reg       <= 1'b0;
            flush_done_reg <= 1'b0;
            overflow_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            wait_cnt_reg   <= wait_cnt_next;
            mem_wr_en_reg  <= win_valid && !bounds_hit;
            if (win_valid && !bounds_hit) begin
                mem_addr_reg <= win_addr;
                mem_data_reg <= win_data;
            end
            busy_reg       <= (fifo_count_next != '0) || (state_next != ST_ARB);
            flush_done_reg <= (state_next == ST_DONE);
            if (bounds_hit) begin
                overflow_reg <= 1'b1;
            end else if (state_reg == ST_DONE) begin
                overflow_reg <= 1'b0;
            end
        end
    end

    assign spec_ready   = spec_win;
    assign flush_done   = flush_done_reg;
    assign mem_wr_en    = mem_wr_en_reg;
    assign mem_addr     = mem_addr_reg;
    assign mem_data     = mem_data_reg;
    assign busy         = busy_reg;
    assign overflow_err = overflow_reg;

endmodule
